// File: rtl/idct_pkg.sv
// idct_pkg: widths, stage bundles, frame-length decode and the
// twiddle table generator shared by the IDCT rotation stage.
package idct_pkg;

  localparam int W_DIN      = 24;
  localparam int W_COEF     = 18;
  localparam int W_DOUT     = 42;
  localparam int W_K        = 11;
  localparam int W_N        = 12;
  localparam int ROM_DEPTH  = 2048;
  localparam int COEF_SCALE = 65536;

  typedef struct packed {
    logic           valid;
    logic           sop;
    logic           eop;
    logic [1:0]     err;
    logic [W_N-1:0] fftpts;
  } ctrl_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] sh;
  } npts_t;

  function automatic npts_t npts_decode(input logic [W_N-1:0] n);
    npts_t r;
    r.ok = 1'b1;
    r.sh = 3'd0;
    unique case (1'b1)
      (n == 12'd64):   r.sh = 3'd5;
      (n == 12'd128):  r.sh = 3'd4;
      (n == 12'd256):  r.sh = 3'd3;
      (n == 12'd512):  r.sh = 3'd2;
      (n == 12'd1024): r.sh = 3'd1;
      (n == 12'd2048): r.sh = 3'd0;
      default:         r.ok = 1'b0;
    endcase
    return r;
  endfunction

  localparam logic signed [127:0] PI_Q60   = 128'sh3243F6A8885A308D;
  localparam logic signed [127:0] ONE_Q60  = 128'sd1 <<< 60;
  localparam logic signed [127:0] HALF_Q60 = 128'sd1 <<< 59;

  // Q60 Taylor series; far more precision than the 2^-16 rounding needs.
  function automatic logic [2*W_COEF-1:0] twiddle_entry(input int m);
    logic signed [127:0] x, x2, tc, ts, sc, ss, rc, rs;
    x  = (PI_Q60 * 128'(m)) >>> 12;
    x2 = (x * x) >>> 60;
    tc = ONE_Q60;
    sc = ONE_Q60;
    ts = x;
    ss = x;
    for (int n = 0; n < 14; n++) begin
      tc = -(((tc * x2) >>> 60) / 128'((2*n+1)*(2*n+2)));
      sc = sc + tc;
      ts = -(((ts * x2) >>> 60) / 128'((2*n+2)*(2*n+3)));
      ss = ss + ts;
    end
    rc = (sc * 128'(COEF_SCALE) + HALF_Q60) >>> 60;
    rs = (ss * 128'(COEF_SCALE) + HALF_Q60) >>> 60;
    return {W_COEF'(rc), W_COEF'(rs)};
  endfunction

endpackage

// File: rtl/idct_twiddle_rom.sv
// idct_twiddle_rom: registered-read cos/sin(pi*m/4096) table,
// m = 0..2047, 2^16 scale.
module idct_twiddle_rom
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [W_K-1:0]           addr,
  output logic signed [W_COEF-1:0] cos_q,
  output logic signed [W_COEF-1:0] sin_q
);

  logic [2*W_COEF-1:0] tbl [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tbl
    localparam logic [2*W_COEF-1:0] ENTRY = twiddle_entry(i);
    assign tbl[i] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (rd_en) begin
      {cos_q, sin_q} <= tbl[addr];
    end
  end

endmodule

// File: rtl/idct_vec_rot.sv
// idct_vec_rot: streaming X[k]*exp(-j*pi*k/2N) rotation with
// frame tracking, 3-stage pipeline stalled by source_ready.
module idct_vec_rot
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic [1:0]               sink_error,
  input  logic                     sink_sop,
  input  logic                     sink_eop,
  input  logic signed [W_DIN-1:0]  sink_real,
  input  logic signed [W_DIN-1:0]  sink_imag,
  input  logic [W_N-1:0]           fftpts_in,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic [1:0]               source_error,
  output logic                     source_sop,
  output logic                     source_eop,
  output logic signed [W_DOUT-1:0] source_real,
  output logic signed [W_DOUT-1:0] source_imag,
  output logic [W_N-1:0]           fftpts_out
);

  logic           en;
  logic           acc;
  npts_t          dec;
  logic [W_K-1:0] k_q;
  logic [W_K-1:0] k_use;
  logic [W_K-1:0] k_nxt;
  logic [W_K-1:0] addr;
  logic [W_N-1:0] n_q;
  logic [W_N-1:0] n_use;
  logic [2:0]     sh_q;
  logic [2:0]     sh_use;
  logic           last;
  logic           ferr;
  ctrl_t          c0, c1, c2, c3;

  logic signed [W_DIN-1:0]  a1, b1;
  logic signed [W_COEF-1:0] cos1, sin1;
  logic signed [W_DOUT-1:0] p_ac, p_bs, p_bc, p_as;
  logic signed [W_DOUT-1:0] re_q, im_q;

  assign en         = source_ready;
  assign sink_ready = source_ready;
  assign acc        = sink_valid & en;
  assign dec        = npts_decode(fftpts_in);

  // sop restarts the frame; eop or the last index closes it
  always_comb begin
    k_use  = k_q;
    n_use  = n_q;
    sh_use = sh_q;
    ferr   = 1'b0;
    if (sink_sop) begin
      k_use  = '0;
      n_use  = dec.ok ? fftpts_in : W_N'(ROM_DEPTH);
      sh_use = dec.sh;
      ferr   = ~dec.ok | (k_q != '0) | sink_eop;
    end
    last = (k_use == W_K'(n_use - 12'd1));
    if (sink_eop & ~last)
      ferr = 1'b1;
    k_nxt = (last | sink_eop) ? '0 : k_use + 11'd1;
    addr  = k_use << sh_use;
  end

  always_comb begin
    c0.valid  = sink_valid;
    c0.sop    = sink_valid & sink_sop;
    c0.eop    = sink_valid & sink_eop;
    c0.err    = sink_valid ? (sink_error | {1'b0, ferr}) : 2'b00;
    c0.fftpts = n_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q  <= '0;
      n_q  <= W_N'(ROM_DEPTH);
      sh_q <= '0;
    end else if (acc) begin
      k_q  <= k_nxt;
      n_q  <= n_use;
      sh_q <= sh_use;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
    end else if (en) begin
      c1 <= c0;
      c2 <= c1;
      c3 <= c2;
    end
  end

  idct_twiddle_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (en),
    .addr  (addr),
    .cos_q (cos1),
    .sin_q (sin1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '0;
      b1 <= '0;
    end else if (en) begin
      a1 <= sink_real;
      b1 <= sink_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ac <= '0;
      p_bs <= '0;
      p_bc <= '0;
      p_as <= '0;
    end else if (en) begin
      p_ac <= W_DOUT'(a1) * W_DOUT'(cos1);
      p_bs <= W_DOUT'(b1) * W_DOUT'(sin1);
      p_bc <= W_DOUT'(b1) * W_DOUT'(cos1);
      p_as <= W_DOUT'(a1) * W_DOUT'(sin1);
    end
  end

  // |sum| <= 2^40, so 42 bits never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en) begin
      re_q <= p_ac + p_bs;
      im_q <= p_bc - p_as;
    end
  end

  assign source_valid = c3.valid;
  assign source_sop   = c3.sop;
  assign source_eop   = c3.eop;
  assign source_error = c3.err;
  assign fftpts_out   = c3.fftpts;
  assign source_real  = re_q;
  assign source_imag  = im_q;

endmodule
